// File: rtl/mem_burst_master_pkg.sv
// Shared definitions for mem_burst_master: FSM state encoding, the data
// word width and the default address/length field widths.
package mem_burst_master_pkg;

  localparam int DATA_W           = 16;
  localparam int ADDR_SIZE_DEFAULT = 16;
  localparam int LEN_SIZE_DEFAULT  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst initiator for the word-addressed memory block.
// Accepts one read or write burst command at a time and sequences the
// memory's address/load/out_en/data_in pins, capturing the memory's
// registered data_out into rd_data.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_write/addr/len    burst direction, first address, length-1
//   wr_data/valid/ready   write word stream (ready only in WRITE)
//   rd_data/rd_valid      read word stream, no backpressure
//   busy, done            not-idle flag, one-cycle completion pulse
//   mem_*                 memory pins (address, load, out_en, data_in/out)
module mem_burst_master
  import mem_burst_master_pkg::*;
#(
  parameter int address_size = ADDR_SIZE_DEFAULT,
  parameter int len_size     = LEN_SIZE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [address_size-1:0] cmd_addr,
  input  logic [len_size-1:0]     cmd_len,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic [address_size-1:0] mem_address,
  output logic                    mem_load,
  output logic                    mem_out_en,
  output logic [DATA_W-1:0]       mem_data_in,
  input  logic [DATA_W-1:0]       mem_data_out
);

  state_t                  state_q, state_d;
  logic [address_size-1:0] addr_q, addr_d;
  logic [len_size-1:0]     cnt_q, cnt_d;
  logic                    issue_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    rd_valid_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read pipeline: issue_q marks the edge at which the memory captured a
  // word; one edge later that word is on mem_data_out and gets registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      issue_q    <= (state_q == ST_READ);
      rd_valid_q <= issue_q;
      if (issue_q) rd_data_q <= mem_data_out;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_load   = 1'b0;
    mem_out_en = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        mem_load = wr_valid;
        if (wr_valid) begin
          addr_d = addr_q + address_size'(1);
          // Terminal test at zero keeps the count from ever wrapping.
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - len_size'(1);
        end
      end
      ST_READ: begin
        mem_out_en = 1'b1;
        addr_d     = addr_q + address_size'(1);
        if (cnt_q == '0) state_d = ST_DRAIN;
        else             cnt_d   = cnt_q - len_size'(1);
      end
      // Lets the last issued word travel through the capture register so
      // its rd_valid lines up with done.
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign mem_address = addr_q;
  assign mem_data_in = wr_data;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

endmodule
